// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings for the byte-serial memory controller.
// Revision    : 1.0 - initial release
//============================================================================
package mem_ctrl_pkg;

    localparam int         c_RAM_ADDR_WIDTH_DEF = 17;
    localparam logic [1:0] c_IO_SEL             = 2'b11;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Unused encoding 3 is treated as a full word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            c_SIZE_BYTE: size_to_bytes = 3'd1;
            c_SIZE_HALF: size_to_bytes = 3'd2;
            c_SIZE_WORD: size_to_bytes = 3'd4;
            default:     size_to_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
//============================================================================
// Module      : mem_ctrl
// Description : Arbitrates fetch and load/store ports onto a byte-wide bus.
// Revision    : 1.0 - initial release
//============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = c_RAM_ADDR_WIDTH_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        if_valid_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] if_data_out,
    input  logic        ls_valid_in,
    input  logic        ls_wr_in,
    input  logic [1:0]  ls_size_in,
    input  logic [31:0] ls_addr_in,
    input  logic [31:0] ls_wdata_in,
    output logic        ls_done_out,
    output logic [31:0] ls_rdata_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_t      r_state,    w_state;
    logic        r_last_ls,  w_last_ls;
    logic        r_is_ls,    w_is_ls;
    logic        r_io_byte,  w_io_byte;
    logic [2:0]  r_nbytes,   w_nbytes;
    logic [31:0] r_base,     w_base;
    logic [31:0] r_wdata,    w_wdata;
    logic [2:0]  r_issue,    w_issue;
    logic [2:0]  r_cap,      w_cap;
    logic        r_p1,       w_p1;
    logic        r_p2,       w_p2;
    logic [31:0] r_buf,      w_buf;
    logic        r_paused;
    logic        r_gap,      w_gap;
    logic        r_done_rd,  w_done_rd;
    logic [31:0] r_mem_a,    w_mem_a;
    logic [7:0]  r_mem_dout, w_mem_dout;
    logic        r_mem_wr,   w_mem_wr;
    logic        r_if_done,  w_if_done;
    logic        r_ls_done,  w_ls_done;
    logic [31:0] r_if_data,  w_if_data;
    logic [31:0] r_ls_rdata, w_ls_rdata;

    logic        w_ls_io, w_ls_ok, w_can_accept, w_grant_ls, w_grant_if;
    logic [31:0] w_sel_addr, w_sel_wdata, w_cap_buf;
    logic [2:0]  w_sel_n;
    logic        w_sel_wr, w_sel_iob, w_last_cap;

    // An IO store that cannot be buffered yet is simply not eligible.
    assign w_ls_io      = (ls_addr_in[RAM_ADDR_WIDTH -: 2] == c_IO_SEL);
    assign w_ls_ok      = ls_valid_in && !(ls_wr_in && w_ls_io && io_buffer_full);
    assign w_can_accept = (r_state == ST_IDLE) && !r_if_done && !r_ls_done && !r_gap;
    assign w_grant_ls   = w_ls_ok && (!if_valid_in || !r_last_ls);
    assign w_grant_if   = if_valid_in && !w_grant_ls;

    assign w_sel_addr  = w_grant_ls ? ls_addr_in : if_addr_in;
    assign w_sel_wr    = w_grant_ls && ls_wr_in;
    assign w_sel_n     = w_grant_ls ? size_to_bytes(ls_size_in) : 3'd4;
    assign w_sel_wdata = ls_wdata_in;
    assign w_sel_iob   = w_grant_ls && ls_wr_in && w_ls_io && (ls_size_in == c_SIZE_BYTE);
    assign w_last_cap  = (r_cap == (r_nbytes - 3'd1));

    always_comb begin
        w_state    = r_state;
        w_last_ls  = r_last_ls;
        w_is_ls    = r_is_ls;
        w_io_byte  = r_io_byte;
        w_nbytes   = r_nbytes;
        w_base     = r_base;
        w_wdata    = r_wdata;
        w_issue    = r_issue;
        w_cap      = r_cap;
        w_p1       = r_p1;
        w_p2       = r_p2;
        w_buf      = r_buf;
        w_gap      = 1'b0;
        w_done_rd  = r_done_rd;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_mem_wr   = r_mem_wr;
        w_if_done  = 1'b0;
        w_ls_done  = 1'b0;
        w_if_data  = r_if_data;
        w_ls_rdata = r_ls_rdata;
        w_cap_buf  = r_buf;
        w_cap_buf[{r_cap[1:0], 3'b000} +: 8] = mem_din;

        case (r_state)
            ST_IDLE: begin
                w_mem_a    = 32'd0;
                w_mem_dout = 8'd0;
                w_mem_wr   = 1'b0;
                // Extra idle cycle after the done cycle of an IO byte store.
                w_gap      = r_ls_done && !r_done_rd && r_io_byte;
                if (w_can_accept && (w_grant_ls || w_grant_if)) begin
                    w_last_ls = w_grant_ls;
                    w_is_ls   = w_grant_ls;
                    w_nbytes  = w_sel_n;
                    w_base    = w_sel_addr;
                    w_wdata   = w_sel_wdata;
                    w_io_byte = w_sel_iob;
                    w_buf     = 32'd0;
                    w_issue   = 3'd1;
                    w_cap     = 3'd0;
                    w_mem_a   = w_sel_addr;
                    w_p2      = 1'b0;
                    if (w_sel_wr) begin
                        w_state    = ST_WRITE;
                        w_mem_dout = w_sel_wdata[7:0];
                        w_mem_wr   = 1'b1;
                        w_p1       = 1'b0;
                    end else begin
                        w_state = ST_READ;
                        w_p1    = 1'b1;
                    end
                end
            end

            ST_READ: begin
                if (clear_in) begin
                    w_state = ST_IDLE;
                    w_mem_a = 32'd0;
                    w_p1    = 1'b0;
                    w_p2    = 1'b0;
                end else if (r_paused) begin
                    // In-flight bytes were lost while paused; restart at the first uncaptured one.
                    w_mem_a = r_base + {29'd0, r_cap};
                    w_issue = r_cap + 3'd1;
                    w_p1    = 1'b1;
                    w_p2    = 1'b0;
                end else begin
                    if (r_p2) begin
                        w_buf = w_cap_buf;
                        w_cap = r_cap + 3'd1;
                    end
                    if (r_p2 && w_last_cap) begin
                        w_state = ST_IDLE;
                        w_mem_a = 32'd0;
                        w_p1    = 1'b0;
                        w_p2    = 1'b0;
                        if (r_is_ls) begin
                            w_ls_rdata = w_cap_buf;
                            w_ls_done  = 1'b1;
                            w_done_rd  = 1'b1;
                        end else begin
                            w_if_data = w_cap_buf;
                            w_if_done = 1'b1;
                        end
                    end else begin
                        w_p2 = r_p1;
                        if (r_issue < r_nbytes) begin
                            w_mem_a = r_base + {29'd0, r_issue};
                            w_issue = r_issue + 3'd1;
                            w_p1    = 1'b1;
                        end else begin
                            w_p1 = 1'b0;
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (r_issue == r_nbytes) begin
                    w_state    = ST_IDLE;
                    w_mem_a    = 32'd0;
                    w_mem_dout = 8'd0;
                    w_mem_wr   = 1'b0;
                    w_ls_done  = 1'b1;
                    w_done_rd  = 1'b0;
                end else begin
                    w_mem_a    = r_base + {29'd0, r_issue};
                    w_mem_dout = r_wdata[{r_issue[1:0], 3'b000} +: 8];
                    w_mem_wr   = 1'b1;
                    w_issue    = r_issue + 3'd1;
                end
            end

            default: w_state = ST_IDLE;
        endcase
    end

    // While paused only the resume marker moves; everything else holds.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_last_ls  <= 1'b0;
            r_is_ls    <= 1'b0;
            r_io_byte  <= 1'b0;
            r_nbytes   <= 3'd0;
            r_base     <= 32'd0;
            r_wdata    <= 32'd0;
            r_issue    <= 3'd0;
            r_cap      <= 3'd0;
            r_p1       <= 1'b0;
            r_p2       <= 1'b0;
            r_buf      <= 32'd0;
            r_paused   <= 1'b0;
            r_gap      <= 1'b0;
            r_done_rd  <= 1'b0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else if (!rdy_in) begin
            r_paused <= 1'b1;
        end else begin
            r_paused   <= 1'b0;
            r_state    <= w_state;
            r_last_ls  <= w_last_ls;
            r_is_ls    <= w_is_ls;
            r_io_byte  <= w_io_byte;
            r_nbytes   <= w_nbytes;
            r_base     <= w_base;
            r_wdata    <= w_wdata;
            r_issue    <= w_issue;
            r_cap      <= w_cap;
            r_p1       <= w_p1;
            r_p2       <= w_p2;
            r_buf      <= w_buf;
            r_gap      <= w_gap;
            r_done_rd  <= w_done_rd;
            r_mem_a    <= w_mem_a;
            r_mem_dout <= w_mem_dout;
            r_mem_wr   <= w_mem_wr;
            r_if_done  <= w_if_done;
            r_ls_done  <= w_ls_done;
            r_if_data  <= w_if_data;
            r_ls_rdata <= w_ls_rdata;
        end
    end

    assign mem_a        = r_mem_a;
    assign mem_dout     = r_mem_dout;
    assign mem_wr       = r_mem_wr & rdy_in;
    assign if_done_out  = r_if_done & ~clear_in;
    assign ls_done_out  = r_ls_done & ~(clear_in & r_done_rd);
    assign if_data_out  = r_if_data;
    assign ls_rdata_out = r_ls_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_ctrl
// Description : Directed scoreboard bench for mem_ctrl with a byte memory model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_ctrl;

    logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, clear_in = 1'b0;
    logic        if_valid_in = 1'b0, ls_valid_in = 1'b0, ls_wr_in = 1'b0;
    logic [31:0] if_addr_in = '0, ls_addr_in = '0, ls_wdata_in = '0;
    logic [1:0]  ls_size_in = '0;
    logic [7:0]  mem_din = '0;
    logic        io_buffer_full = 1'b0;
    logic        if_done_out, ls_done_out, mem_wr;
    logic [31:0] if_data_out, ls_rdata_out, mem_a;
    logic [7:0]  mem_dout;

    always #5 clk_in = ~clk_in;

    mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_valid_in(if_valid_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .ls_valid_in(ls_valid_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
        .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in),
        .ls_done_out(ls_done_out), .ls_rdata_out(ls_rdata_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // Byte memory: address sampled at an edge, data presented right after it.
    logic [7:0] mem [logic [31:0]];
    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction
    always @(posedge clk_in) begin
        mem_din <= rd(mem_a);
        if (mem_wr) mem[mem_a] = mem_dout;
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int total = 0, bad = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic rd; logic [31:0] d; } lse_t;
    wr_t         wq[$];
    lse_t        lq[$];
    logic [31:0] iq[$];
    int n_wr = 0, n_if = 0, n_ls = 0, if_cyc = 0, ls_cyc = 0;

    always @(negedge clk_in) begin : mon
        wr_t         we;
        lse_t        le;
        logic [31:0] ie;
        if (mem_wr) begin
            n_wr++;
            chk("wr_expected", {31'd0, wq.size() != 0}, 32'd1);
            if (wq.size() != 0) begin
                we = wq.pop_front();
                chk("wr_addr", mem_a, we.a);
                chk("wr_data", {24'd0, mem_dout}, {24'd0, we.d});
            end
        end
        if (if_done_out) begin
            n_if++;
            if_cyc = cyc;
            chk("if_done_expected", {31'd0, iq.size() != 0}, 32'd1);
            if (iq.size() != 0) begin
                ie = iq.pop_front();
                chk("if_data", if_data_out, ie);
            end
        end
        if (ls_done_out) begin
            n_ls++;
            ls_cyc = cyc;
            chk("ls_done_expected", {31'd0, lq.size() != 0}, 32'd1);
            if (lq.size() != 0) begin
                le = lq.pop_front();
                if (le.rd) chk("ls_rdata", ls_rdata_out, le.d);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_ls(input string tag);
        int   b;
        logic ok;
        b  = n_ls;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (n_ls != b) begin ok = 1'b1; break; end
        end
        ls_valid_in = 1'b0;
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_if(input string tag);
        int   b;
        logic ok;
        b  = n_if;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (n_if != b) begin ok = 1'b1; break; end
        end
        if_valid_in = 1'b0;
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    // Both ports raised together; each valid drops after its own done.
    task automatic wait_both(input string tag);
        int bl, bi;
        bl = n_ls;
        bi = n_if;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ls_valid_in && n_ls != bl) ls_valid_in = 1'b0;
            if (if_valid_in && n_if != bi) if_valid_in = 1'b0;
            if (!ls_valid_in && !if_valid_in) break;
        end
        chk(tag, {30'd0, ls_valid_in, if_valid_in}, 32'd0);
        ls_valid_in = 1'b0;
        if_valid_in = 1'b0;
    endtask

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic start_ls(input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
        ls_wr_in = wr; ls_size_in = sz; ls_addr_in = a; ls_wdata_in = wd;
        ls_valid_in = 1'b1;
    endtask

    task automatic push_writes(input logic [31:0] a, input logic [31:0] wd, input int n);
        logic [31:0] w;
        w = wd;
        for (int k = 0; k < n; k++) begin
            wq.push_back('{a: a + 32'(k), d: w[7:0]});
            w = w >> 8;
        end
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
        int t0;
        push_writes(a, wd, nb(sz));
        lq.push_back('{rd: 1'b0, d: 32'd0});
        start_ls(1'b1, sz, a, wd);
        t0 = cyc + 1;
        wait_ls({tag, "_tmo"});
        chk({tag, "_lat"}, 32'(ls_cyc - t0), 32'(nb(sz)));
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] exp);
        int t0;
        lq.push_back('{rd: 1'b1, d: exp});
        start_ls(1'b0, sz, a, 32'd0);
        t0 = cyc + 1;
        wait_ls({tag, "_tmo"});
        chk({tag, "_lat"}, 32'(ls_cyc - t0), 32'(nb(sz) + 1));
    endtask

    initial begin : stim
        int t0, b, bw;
        mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h05;
        mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
        mem[32'h100]  = 8'hD4; mem[32'h101]  = 8'hC3;
        mem[32'h102]  = 8'hB2; mem[32'h103]  = 8'hA1;

        repeat (3) step();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_outs", {28'd0, mem_wr, if_done_out, ls_done_out, 1'b0}, 32'd0);
        chk("rst_if_data", if_data_out, 32'd0);
        rst_n_in = 1'b1;
        step();

        // Plain fetch
        iq.push_back(32'h0000_0513);
        if_addr_in = 32'h1000; if_valid_in = 1'b1;
        t0 = cyc + 1;
        wait_if("fetch_tmo");
        chk("fetch_lat", 32'(if_cyc - t0), 32'd5);

        // Tie: ls wins, then the fetch follows
        push_writes(32'h2000, 32'hDEAD_BEEF, 4);
        lq.push_back('{rd: 1'b0, d: 32'd0});
        iq.push_back(32'h0000_0513);
        start_ls(1'b1, 2'd2, 32'h2000, 32'hDEAD_BEEF);
        if_valid_in = 1'b1;
        t0 = cyc + 1;
        wait_both("tie_tmo");
        chk("tie_ls_lat", 32'(ls_cyc - t0), 32'd4);
        chk("tie_if_lat", 32'(if_cyc - t0), 32'd11);

        do_load("ld_word", 2'd2, 32'h2000, 32'hDEAD_BEEF);
        do_load("ld_byte", 2'd0, 32'h2001, 32'h0000_00BE);
        do_load("ld_half", 2'd1, 32'h2001, 32'h0000_ADBE);
        do_store("st_wrap", 2'd2, 32'hFFFF_FFFE, 32'h1122_3344);
        do_load("ld_wrap", 2'd2, 32'hFFFF_FFFF, 32'h0011_2233);

        // IO byte store held off by a full buffer, then one idle cycle
        io_buffer_full = 1'b1;
        start_ls(1'b1, 2'd0, 32'h0003_0000, 32'h0000_AB41);
        b = n_ls; bw = n_wr;
        repeat (10) step();
        chk("io_held_wr", 32'(n_wr - bw), 32'd0);
        chk("io_held_done", 32'(n_ls - b), 32'd0);
        wq.push_back('{a: 32'h0003_0000, d: 8'h41});
        lq.push_back('{rd: 1'b0, d: 32'd0});
        io_buffer_full = 1'b0;
        t0 = cyc + 1;
        wait_ls("io_tmo");
        chk("io_lat", 32'(ls_cyc - t0), 32'd1);
        iq.push_back(32'h0000_0513);
        if_addr_in = 32'h1000; if_valid_in = 1'b1;
        wait_if("io_gap_tmo");
        chk("io_gap_lat", 32'(if_cyc - t0), 32'd9);

        // Clear aborts a load
        b = n_ls;
        start_ls(1'b0, 2'd2, 32'h100, 32'd0);
        repeat (3) step();
        clear_in = 1'b1; ls_valid_in = 1'b0;
        step();
        clear_in = 1'b0;
        chk("clr_idle_mem_a", mem_a, 32'd0);
        repeat (8) step();
        chk("clr_no_done", 32'(n_ls - b), 32'd0);

        // Clear does not disturb a store, even during its done cycle
        push_writes(32'h200, 32'h5566_7788, 4);
        lq.push_back('{rd: 1'b0, d: 32'd0});
        start_ls(1'b1, 2'd2, 32'h200, 32'h5566_7788);
        t0 = cyc + 1;
        repeat (2) step();
        clear_in = 1'b1;
        wait_ls("clr_st_tmo");
        clear_in = 1'b0;
        chk("clr_st_lat", 32'(ls_cyc - t0), 32'd4);

        // Pause mid-read: reissue from the first uncaptured byte
        lq.push_back('{rd: 1'b1, d: 32'hA1B2_C3D4});
        start_ls(1'b0, 2'd2, 32'h100, 32'd0);
        t0 = cyc + 1;
        repeat (3) step();
        rdy_in = 1'b0;
        repeat (3) step();
        rdy_in = 1'b1;
        wait_ls("pause_tmo");
        chk("pause_lat", 32'(ls_cyc - t0), 32'd10);

        // Reset in the middle of a word store
        push_writes(32'h300, 32'h0000_BBCC, 2);
        start_ls(1'b1, 2'd2, 32'h300, 32'h99AA_BBCC);
        repeat (2) step();
        rst_n_in = 1'b0; ls_valid_in = 1'b0;
        step();
        chk("mrst_mem_a", mem_a, 32'd0);
        chk("mrst_outs", {24'd0, mem_dout}, 32'd0);
        chk("mrst_flags", {29'd0, mem_wr, if_done_out, ls_done_out}, 32'd0);
        chk("mrst_rdata", ls_rdata_out, 32'd0);
        chk("mrst_if_data", if_data_out, 32'd0);
        rst_n_in = 1'b1;
        b = n_ls;
        repeat (5) step();
        chk("mrst_no_done", 32'(n_ls - b), 32'd0);
        chk("mrst_wr_seen", 32'(wq.size()), 32'd0);

        // After reset the tie goes to ls again
        lq.push_back('{rd: 1'b1, d: 32'h0000_BBCC});
        iq.push_back(32'h0000_0513);
        start_ls(1'b0, 2'd2, 32'h300, 32'd0);
        if_addr_in = 32'h1000; if_valid_in = 1'b1;
        t0 = cyc + 1;
        wait_both("rr_tmo");
        chk("rr_ls_lat", 32'(ls_cyc - t0), 32'd5);
        chk("rr_if_lat", 32'(if_cyc - t0), 32'd12);

        repeat (3) step();
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("lq_empty", 32'(lq.size()), 32'd0);
        chk("iq_empty", 32'(iq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
